ltpi_tx_frame_scheduler: RTL and testbench
==========================================

# ltpi_tx_frame_scheduler

Frame-level scheduler in front of the LTPI PHY TX: arbitrates between training, data-channel and default-IO frame sources and serialises the winner as 16 byte-symbols to the 8b/10b PHY TX. It inserts the K28.5 comma and, optionally, the CRC-8 byte. Frames are back-to-back with no gap symbols.

## Interface
- FRAME_BYTES, 16, symbols per frame (fixed; other values unsupported)
- DATA_MAX_CONSEC, 3, max consecutive data frames before one default frame is forced (1..15)
- Clock/reset: one clock; reset is synchronous and active-high.
- clk  in  1  symbol clock
- reset  in  1  synchronous active-high reset
- enable  in  1  start/continue frame stream
- link_operational  in  1  0 = training mode, 1 = operational mode
- trn_valid / trn_ready  in/out  1/1  training frame handshake
- trn_frame  in  128  training frame; byte i = bits [8i+7:8i]
- data_valid / data_ready  in/out  1/1  data-channel frame handshake
- data_frame  in  128  data frame
- dflt_frame  in  128  default IO frame; always available, no handshake
- tx_ready  in  1  PHY accepts the current symbol
- tx_data  out  8  symbol byte
- tx_k  out  1  K-symbol flag
- tx_valid  out  1  symbol valid
- tx_frame_start  out  1  high while byte 0 is presented
- tx_src  out  2  source of current frame: 0 idle, 1 trn, 2 data, 3 dflt
- frame_cnt  out  16  frames completed, wraps 0xFFFF→0

## Operation
- States: IDLE, SEND. Reset → IDLE. Reset values: tx_data=0, tx_k=0, tx_valid=0, tx_frame_start=0, tx_src=0, frame_cnt=0, byte counter=0, consecutive-data counter=0, ready outputs=0.
- A selection cycle is IDLE with enable=1, or SEND with byte 15 accepted (tx_valid&&tx_ready) and enable=1.
- Selection, training mode: trn if trn_valid, else idle frame (comma plus 15 zero bytes, tx_src=0).
- Selection, operational mode: data if data_valid and consec<DATA_MAX_CONSEC; else dflt. A data grant increments consec; a dflt grant clears it. consec is also cleared while link_operational=0.
- trn_ready/data_ready are combinational, high only in a selection cycle for the granted source. The frame is latched at that edge.
- Byte 0 is always replaced by 8'hBC with tx_k=1. Bytes 1..15 come from the latched frame with tx_k=0.
- The byte counter advances only on tx_valid&&tx_ready. tx_ready low holds all outputs stable.
- Byte 15 accepted with enable=0 → IDLE, tx_valid=0. Deasserting enable mid-frame always completes the current frame.
- frame_cnt increments on each accepted byte 15.
- A link_operational change mid-frame takes effect at the next selection.
- Reset mid-frame abandons the partial frame immediately. No ready pulse is issued for it.

## Timing
- enable high at edge E in IDLE → byte 0 on outputs after E (1-cycle latency).
- Steady state with tx_ready=1: one frame per 16 cycles, zero gap.
- All tx_* outputs are registered. Ready outputs are combinational from the state and input valids.

## Configuration
- LTPI_TX_CRC_EN defined: byte 15 is replaced by CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR) over latched bytes 1..14. The CRC is computed at latch time and stored. The idle frame therefore carries CRC 0x00.
- LTPI_TX_CRC_EN undefined: byte 15 is passed from the source frame unchanged. No CRC logic is present.

## Structure
- Package ltpi_tx_sched_pkg holds:
  - src enum (IDLE/TRN/DATA/DFLT)
  - COMMA_K28_5 = 8'hBC
  - FRAME_BYTES
  - CRC8_POLY = 8'h07
- Sub-module ltpi_tx_sched_crc8: combinational CRC-8 over 14 bytes. Instantiated only under LTPI_TX_CRC_EN.

## Test plan
- Reset, then enable=1, training mode, trn_valid=1 with frame bytes i=i:
  - one trn_ready pulse;
  - stream BC(k=1), 01..0F;
  - tx_frame_start on byte 0 only;
  - frame_cnt=1 after 16 cycles.
- Operational mode, data_valid held 1, DATA_MAX_CONSEC=3 → tx_src sequence 2,2,2,3,2,2,2,3; frame boundaries have no gap cycles.
- Toggle tx_ready randomly (~50%) → the byte sequence is identical to the tx_ready=1 case, and outputs are held while tx_ready=0.
- Deassert enable at byte 5 → the frame completes through byte 15, then tx_valid=0 and state is IDLE. Assert reset at byte 7 of the next frame → all outputs 0 on the next cycle.
- Training mode with trn_valid=0 → idle frame BC then 15×00, tx_src=0, no ready pulses.
- With LTPI_TX_CRC_EN, bytes 1..14 = 0x01..0x0E → byte 15 equals the reference-model CRC-8. Without the macro, byte 15 equals the input byte 15.

Source files
------------

// File: rtl/ltpi_tx_sched_pkg.sv
// ltpi_tx_sched_pkg
// Shared types and constants for the LTPI TX frame scheduler:
//   src_e        - frame source reported on tx_src (IDLE/TRN/DATA/DFLT)
//   state_e      - scheduler state (IDLE/SEND)
//   COMMA_K28_5  - K28.5 comma placed in byte 0 of every frame
//   FRAME_BYTES  - symbols per frame
//   CRC8_POLY    - CRC-8 generator polynomial (x^8+x^2+x+1)
//   crc8_update  - folds one byte into a running MSB-first CRC-8
// Used by the optional CRC path (LTPI_TX_CRC_EN).
package ltpi_tx_sched_pkg;

  typedef enum logic [1:0] {
    SRC_IDLE = 2'd0,
    SRC_TRN  = 2'd1,
    SRC_DATA = 2'd2,
    SRC_DFLT = 2'd3
  } src_e;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_e;

  localparam logic [7:0]  COMMA_K28_5 = 8'hBC;
  localparam int unsigned FRAME_BYTES = 16;
  localparam logic [7:0]  CRC8_POLY   = 8'h07;

  function automatic logic [7:0] crc8_update(input logic [7:0] crc_in,
                                             input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int unsigned b = 0; b < 8; b++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/ltpi_tx_sched_crc8.sv
// ltpi_tx_sched_crc8
// Combinational CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR)
// over the 14 payload bytes of a frame. Only instantiated when
// LTPI_TX_CRC_EN is defined.
//   bytes_in  in  112  payload; frame byte 1 at [7:0], byte 14 at [111:104]
//   crc       out 8    CRC over bytes 1..14, byte 1 first
module ltpi_tx_sched_crc8
  import ltpi_tx_sched_pkg::*;
(
  input  logic [8*(FRAME_BYTES-2)-1:0] bytes_in,
  output logic [7:0]                   crc
);

  always_comb begin
    crc = '0;
    for (int unsigned i = 0; i < FRAME_BYTES - 2; i++) begin
      crc = crc8_update(crc, bytes_in[8*i +: 8]);
    end
  end

endmodule

// File: rtl/ltpi_tx_frame_scheduler.sv
// ltpi_tx_frame_scheduler
// Arbitrates between training, data-channel and default-IO frame sources and
// serialises the winning 16-byte frame, one symbol per accepted cycle, to the
// 8b/10b PHY TX. Byte 0 is always the K28.5 comma. Frames run back-to-back.
// Optional feature: define LTPI_TX_CRC_EN to replace byte 15 with a CRC-8
// over bytes 1..14 (computed when the frame is latched).
// Ports:
//   clk, reset            symbol clock, synchronous active-high reset
//   enable                start/continue the frame stream
//   link_operational      0 = training mode, 1 = operational mode
//   trn_valid/trn_ready   training frame handshake, trn_frame (128)
//   data_valid/data_ready data-channel frame handshake, data_frame (128)
//   dflt_frame (128)      default IO frame, always available
//   tx_ready              PHY accepts the current symbol
//   tx_data/tx_k/tx_valid symbol byte, K flag, valid
//   tx_frame_start        high while byte 0 is presented
//   tx_src                0 idle, 1 trn, 2 data, 3 dflt
//   frame_cnt             completed frames, wraps
module ltpi_tx_frame_scheduler #(
  parameter int unsigned FRAME_BYTES     = 16,
  parameter int unsigned DATA_MAX_CONSEC = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         link_operational,
  input  logic         trn_valid,
  output logic         trn_ready,
  input  logic [127:0] trn_frame,
  input  logic         data_valid,
  output logic         data_ready,
  input  logic [127:0] data_frame,
  input  logic [127:0] dflt_frame,
  input  logic         tx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_k,
  output logic         tx_valid,
  output logic         tx_frame_start,
  output logic [1:0]   tx_src,
  output logic [15:0]  frame_cnt
);
  import ltpi_tx_sched_pkg::*;

  localparam logic [3:0] LAST_BYTE  = 4'(FRAME_BYTES - 1);
  localparam logic [3:0] CONSEC_MAX = 4'(DATA_MAX_CONSEC);

  state_e       state;
  logic [127:0] frame_q;
  logic [3:0]   byte_cnt;
  logic [3:0]   consec;

  logic         last_accept;
  logic         sel;
  src_e         grant;
  logic [127:0] grant_frame;
  logic [3:0]   next_cnt;
  logic [7:0]   next_byte;

  assign last_accept = (state == ST_SEND) && tx_valid && tx_ready && (byte_cnt == LAST_BYTE);
  // Selection: idle and enabled, or the last byte leaves while still enabled.
  assign sel = !reset && enable && ((state == ST_IDLE) || last_accept);

  always_comb begin
    grant       = SRC_IDLE;
    grant_frame = '0;
    if (!link_operational) begin
      if (trn_valid) begin
        grant       = SRC_TRN;
        grant_frame = trn_frame;
      end
    end else if (data_valid && (consec < CONSEC_MAX)) begin
      grant       = SRC_DATA;
      grant_frame = data_frame;
    end else begin
      grant       = SRC_DFLT;
      grant_frame = dflt_frame;
    end
  end

  assign trn_ready  = sel && (grant == SRC_TRN);
  assign data_ready = sel && (grant == SRC_DATA);
  assign next_cnt   = byte_cnt + 4'd1;

`ifdef LTPI_TX_CRC_EN
  logic [7:0] crc_calc;
  logic [7:0] crc_q;

  ltpi_tx_sched_crc8 u_crc8 (
    .bytes_in (grant_frame[119:8]),
    .crc      (crc_calc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= '0;
    end else if (sel) begin
      crc_q <= crc_calc;
    end
  end

  assign next_byte = (next_cnt == LAST_BYTE) ? crc_q : frame_q[{next_cnt, 3'b000} +: 8];
`else
  assign next_byte = frame_q[{next_cnt, 3'b000} +: 8];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      frame_q        <= '0;
      byte_cnt       <= '0;
      consec         <= '0;
      tx_data        <= '0;
      tx_k           <= 1'b0;
      tx_valid       <= 1'b0;
      tx_frame_start <= 1'b0;
      tx_src         <= '0;
      frame_cnt      <= '0;
    end else begin
      if (!link_operational) begin
        consec <= '0;
      end

      if (sel) begin
        state          <= ST_SEND;
        frame_q        <= grant_frame;
        byte_cnt       <= '0;
        tx_data        <= COMMA_K28_5;
        tx_k           <= 1'b1;
        tx_valid       <= 1'b1;
        tx_frame_start <= 1'b1;
        tx_src         <= grant;
        if (link_operational) begin
          consec <= (grant == SRC_DATA) ? consec + 4'd1 : '0;
        end
      end else if ((state == ST_SEND) && tx_valid && tx_ready) begin
        if (byte_cnt == LAST_BYTE) begin
          state          <= ST_IDLE;
          byte_cnt       <= '0;
          tx_data        <= '0;
          tx_k           <= 1'b0;
          tx_valid       <= 1'b0;
          tx_frame_start <= 1'b0;
          tx_src         <= '0;
        end else begin
          byte_cnt       <= next_cnt;
          tx_data        <= next_byte;
          tx_k           <= 1'b0;
          tx_frame_start <= 1'b0;
        end
      end

      if (last_accept) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ltpi_tx_frame_scheduler.sv
// tb_ltpi_tx_frame_scheduler
// Self-checking bench for ltpi_tx_frame_scheduler (DATA_MAX_CONSEC=3).
// Honours LTPI_TX_CRC_EN the same way as the design.
module tb_ltpi_tx_frame_scheduler;

  localparam int MAXC = 3;
  localparam int K    = 3;

  logic         clk = 1'b0;
  logic         reset, enable, link_operational;
  logic         trn_valid, trn_ready, data_valid, data_ready;
  logic [127:0] trn_frame, data_frame, dflt_frame;
  logic         tx_ready;
  logic [7:0]   tx_data;
  logic         tx_k, tx_valid, tx_frame_start;
  logic [1:0]   tx_src;
  logic [15:0]  frame_cnt;

  ltpi_tx_frame_scheduler #(.FRAME_BYTES(16), .DATA_MAX_CONSEC(MAXC)) dut (
    .clk(clk), .reset(reset), .enable(enable), .link_operational(link_operational),
    .trn_valid(trn_valid), .trn_ready(trn_ready), .trn_frame(trn_frame),
    .data_valid(data_valid), .data_ready(data_ready), .data_frame(data_frame),
    .dflt_frame(dflt_frame), .tx_ready(tx_ready), .tx_data(tx_data), .tx_k(tx_k),
    .tx_valid(tx_valid), .tx_frame_start(tx_frame_start), .tx_src(tx_src),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int trn_pulses = 0;
  int data_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference CRC: remainder of (bytes 1..14, then 8 zero bits) divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc_ref(input logic [127:0] f);
    logic [7:0] rem;
    logic       top;
    logic [7:0] byt;
    rem = '0;
    for (int i = 1; i <= 15; i++) begin
      byt = (i == 15) ? 8'h00 : f[8*i +: 8];
      for (int b = 7; b >= 0; b--) begin
        top = rem[7];
        rem = {rem[6:0], byt[b]};
        if (top) rem = rem ^ 8'h07;
      end
    end
    return rem;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [127:0] f, input int i);
    if (i == 0) return 8'hBC;
`ifdef LTPI_TX_CRC_EN
    if (i == 15) return crc_ref(f);
`endif
    return f[8*i +: 8];
  endfunction

  typedef struct packed {
    logic       k;
    logic [7:0] d;
    logic [1:0] src;
    logic       start;
  } sym_t;

  sym_t got[$];
  sym_t exp_q[$];

  task automatic push_frame(input logic [1:0] src, input logic [127:0] f);
    for (int i = 0; i < 16; i++)
      exp_q.push_back(sym_t'{(i == 0), exp_byte(f, i), src, (i == 0)});
  endtask

  // Monitor: counts ready pulses, records accepted symbols, checks stall hold.
  bit          mon_en = 1'b0;
  bit          stall_prev = 1'b0;
  logic [12:0] held;
  always @(negedge clk) begin
    if (trn_ready) trn_pulses++;
    if (data_ready) data_pulses++;
    if (mon_en) begin
      if (stall_prev) chk("hold", {19'd0, tx_valid, tx_k, tx_data, tx_src, tx_frame_start}, {19'd0, held});
      if (tx_valid && tx_ready) got.push_back(sym_t'{tx_k, tx_data, tx_src, tx_frame_start});
      stall_prev = tx_valid && !tx_ready;
      held = {tx_valid, tx_k, tx_data, tx_src, tx_frame_start};
    end else begin
      stall_prev = 1'b0;
    end
  end

  typedef struct {
    logic       rdy;
    logic [7:0] data;
    logic       k;
    logic       start;
    logic [1:0] src;
  } vec_t;
  vec_t tbl[20];

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] tf, df, ff;
    int idx, m_consec, exp_dp, gaps, n;
    bit found, link, tv, dv;
    logic [1:0] es;

    reset = 1'b1; enable = 1'b0; link_operational = 1'b0;
    trn_valid = 1'b0; data_valid = 1'b0; tx_ready = 1'b0;
    trn_frame = '0; data_frame = '0; dflt_frame = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_k", tx_k, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_start", tx_frame_start, 0);
    chk("rst_tx_src", tx_src, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_readies", {trn_ready, data_ready}, 0);

    // Training frame, bytes i=i, with a tx_ready stall pattern (table driven)
    for (int i = 0; i < 16; i++) tf[8*i +: 8] = 8'(i);
    idx = 0;
    for (int s = 0; s < 20; s++) begin
      tbl[s].rdy   = !(s == 2 || s == 3 || s == 9 || s == 14);
      tbl[s].data  = exp_byte(tf, idx);
      tbl[s].k     = (idx == 0);
      tbl[s].start = (idx == 0);
      tbl[s].src   = 2'd1;
      if (tbl[s].rdy) idx++;
    end
    reset = 1'b0; trn_pulses = 0; data_pulses = 0;
    enable = 1'b1; trn_valid = 1'b1; trn_frame = tf; tx_ready = 1'b1;
    #1;
    chk("t1_trn_ready", trn_ready, 1);
    tick();
    trn_valid = 1'b0;
    for (int s = 0; s < 20; s++) begin
      tx_ready = tbl[s].rdy;
      chk("t1_data", tx_data, tbl[s].data);
      chk("t1_k", tx_k, tbl[s].k);
      chk("t1_start", tx_frame_start, tbl[s].start);
      chk("t1_src", tx_src, tbl[s].src);
      chk("t1_valid", tx_valid, 1);
      tick();
    end
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_trn_pulses", trn_pulses, 1);
    chk("t1_next_src_idle", tx_src, 0);
    chk("t1_next_start", tx_frame_start, 1);

    // Operational, data always valid: 2,2,2,3,... with no gaps
    link_operational = 1'b1; data_valid = 1'b1; tx_ready = 1'b1;
    data_frame = {$urandom, $urandom, $urandom, $urandom};
    dflt_frame = {$urandom, $urandom, $urandom, $urandom};
    data_pulses = 0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      found = tx_frame_start && (tx_src != 2'd0);
    end
    chk("t2_sync", {31'd0, found}, 1);
    m_consec = 0; exp_dp = 0; gaps = 0;
    for (int f = 0; f < 9; f++) begin
      if (m_consec < MAXC) begin es = 2'd2; m_consec++; exp_dp++; end
      else begin es = 2'd3; m_consec = 0; end
      chk("t2_src", tx_src, es);
      chk("t2_start", tx_frame_start, 1);
      if (f < 8) begin
        for (int b = 0; b < 16; b++) begin
          if (!tx_valid) gaps++;
          tick();
        end
      end
    end
    chk("t2_gaps", gaps, 0);
    chk("t2_data_pulses", data_pulses, exp_dp);
    enable = 1'b0;
    n = 0;
    while (tx_valid && n < 40) begin tick(); n++; end
    chk("t2_idle", tx_valid, 0);

    // Random rounds: random ready, random mode/valids/frames vs model
    for (int r = 0; r < 6; r++) begin
      link = 1'($urandom % 2); tv = 1'($urandom % 2); dv = 1'($urandom % 2);
      tf = {$urandom, $urandom, $urandom, $urandom};
      df = {$urandom, $urandom, $urandom, $urandom};
      ff = {$urandom, $urandom, $urandom, $urandom};
      link_operational = link; trn_valid = tv; data_valid = dv;
      trn_frame = tf; data_frame = df; dflt_frame = ff;
      exp_q.delete(); got.delete();
      if (!link) m_consec = 0;
      for (int f = 0; f < K; f++) begin
        if (!link) begin
          if (tv) push_frame(2'd1, tf); else push_frame(2'd0, '0);
        end else if (dv && m_consec < MAXC) begin
          push_frame(2'd2, df); m_consec++;
        end else begin
          push_frame(2'd3, ff); m_consec = 0;
        end
      end
      mon_en = 1'b1; enable = 1'b1;
      n = 0;
      while (n < 400 && !(got.size() == 16*K && !tx_valid)) begin
        tx_ready = 1'($urandom % 2);
        if (got.size() > 16*(K-1)) enable = 1'b0;
        tick();
        n++;
      end
      mon_en = 1'b0; enable = 1'b0;
      chk("t3_count", got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
        chk($sformatf("t3_sym_r%0d_i%0d", r, i), {20'd0, got[i]}, {20'd0, exp_q[i]});
    end

    // Enable dropped at byte 5, then reset at byte 7 of the next frame
    ff = {$urandom, $urandom, $urandom, $urandom};
    link_operational = 1'b1; data_valid = 1'b1; data_frame = ff; dflt_frame = ff;
    tx_ready = 1'b1; enable = 1'b1;
    tick();
    chk("t4_b0", tx_data, 8'hBC);
    repeat (5) tick();
    chk("t4_b5", tx_data, ff[47:40]);
    enable = 1'b0;
    repeat (10) tick();
    chk("t4_b15_valid", tx_valid, 1);
    chk("t4_b15", tx_data, exp_byte(ff, 15));
    tick();
    chk("t4_end_valid", tx_valid, 0);
    chk("t4_end_src", tx_src, 0);
    chk("t4_end_ready", {trn_ready, data_ready}, 0);
    tick();
    chk("t4_stay_idle", tx_valid, 0);
    enable = 1'b1;
    tick();
    chk("t4_f2_b0", tx_frame_start, 1);
    repeat (7) tick();
    chk("t4_f2_b7", tx_data, ff[63:56]);
    reset = 1'b1; enable = 1'b0;
    #1;
    chk("t4_rst_ready", {trn_ready, data_ready}, 0);
    tick();
    chk("t4_rst_data", tx_data, 0);
    chk("t4_rst_k", tx_k, 0);
    chk("t4_rst_valid", tx_valid, 0);
    chk("t4_rst_start", tx_frame_start, 0);
    chk("t4_rst_src", tx_src, 0);
    chk("t4_rst_cnt", frame_cnt, 0);

    // Training mode, no training frame: idle frame, no ready pulses
    reset = 1'b0; link_operational = 1'b0; trn_valid = 1'b0; data_valid = 1'b1;
    enable = 1'b1; tx_ready = 1'b1; trn_pulses = 0; data_pulses = 0;
    #1;
    chk("t5_ready", {trn_ready, data_ready}, 0);
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("t5_data", tx_data, (i == 0) ? 8'hBC : 8'h00);
      chk("t5_k", tx_k, (i == 0) ? 1 : 0);
      chk("t5_src", tx_src, 0);
      tick();
    end
    chk("t5_pulses", trn_pulses + data_pulses, 0);
    chk("t5_frame_cnt", frame_cnt, 1);
    enable = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
